// File: rtl/instr_encoder_loader_if.sv
// instr_encoder_loader_if: field-bundle handshake plus instruction-memory write port.
//   in_valid/in_ready          valid/ready handshake for one decoded instruction bundle
//   in_kind, in_alu_sel        class (00 lw, 01 sw, 10 R-type, 11 beq) and R-type {funct7[5], funct3}
//   in_rd, in_rs1, in_rs2      register fields
//   in_imm, in_last            13-bit signed immediate, end-of-program flag
//   imem_we/addr/wdata         write strobe, word address and encoded word
// Modport slave is the encoder side; master is the producer/memory side.
interface instr_encoder_loader_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_kind;
  logic [3:0]        in_alu_sel;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [12:0]       in_imm;
  logic              in_last;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport slave (
    input  in_valid, in_kind, in_alu_sel, in_rd, in_rs1, in_rs2, in_imm, in_last,
    output in_ready, imem_we, imem_addr, imem_wdata
  );

  modport master (
    output in_valid, in_kind, in_alu_sel, in_rd, in_rs1, in_rs2, in_imm, in_last,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: packs decoded instruction fields into RV32I words (lw, sw, R-type, beq)
// and writes them sequentially into instruction memory, one word per two cycles at most.
// Ports:
//   clk, rst     clock; synchronous active-high reset
//   clear        synchronous restart (address, count, err, done, full)
//   bus          instr_encoder_loader_if.slave: bundle handshake and imem write port
//   word_count   number of words written since reset/clear
//   full         last memory word has been written
//   done         program complete (last-flagged bundle handled)
//   err          sticky: an illegal bundle was rejected
// Build option: define HALT_APPEND_EN to append a beq x0,x0,0 self-loop after the last word.
module instr_encoder_loader #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  instr_encoder_loader_if.slave  bus,
  output logic [ADDR_W:0]        word_count,
  output logic                   full,
  output logic                   done,
  output logic                   err
);

  localparam logic [1:0] ST_READY = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;
  localparam logic [1:0] ST_FULL  = 2'd3;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              last_q, last_d;
  logic              err_q, err_d;
  logic              full_q, full_d;
`ifdef HALT_APPEND_EN
  localparam logic [31:0] HALT_WORD = 32'h0000_0063;
  // Set while the appended halt word is the one being written.
  logic              halt_q, halt_d;
`endif

  logic [31:0] enc_word;
  logic        illegal;
  logic        xfer;
  logic        at_end;

  assign bus.in_ready = (state_q == ST_READY) & ~clear;
  assign xfer         = bus.in_valid & bus.in_ready;
  assign at_end       = &addr_q;

  // Encode the presented bundle; unused fields of a class are simply dropped.
  always_comb begin
    enc_word = '0;
    unique case (bus.in_kind)
      2'b00: enc_word = {bus.in_imm[11:0], bus.in_rs1, 3'b010, bus.in_rd, OP_LOAD};
      2'b01: enc_word = {bus.in_imm[11:5], bus.in_rs2, bus.in_rs1, 3'b010, bus.in_imm[4:0],
                         OP_STORE};
      2'b10: enc_word = {1'b0, bus.in_alu_sel[3], 5'b00000, bus.in_rs2, bus.in_rs1,
                         bus.in_alu_sel[2:0], bus.in_rd, OP_REG};
      2'b11: enc_word = {bus.in_imm[12], bus.in_imm[10:5], bus.in_rs2, bus.in_rs1, 3'b000,
                         bus.in_imm[4:1], bus.in_imm[11], OP_BRANCH};
      default: enc_word = '0;
    endcase
  end

  // lw/sw offsets must fit 12 signed bits; branch offsets must be even.
  always_comb begin
    illegal = 1'b0;
    case (bus.in_kind)
      2'b00, 2'b01: illegal = bus.in_imm[12] ^ bus.in_imm[11];
      2'b11:        illegal = bus.in_imm[0];
      default:      illegal = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    count_d = count_q;
    wdata_d = wdata_q;
    last_d  = last_q;
    err_d   = err_q;
    full_d  = full_q;
`ifdef HALT_APPEND_EN
    halt_d  = halt_q;
`endif

    case (state_q)
      ST_READY: begin
        if (xfer) begin
          if (illegal) begin
            err_d = 1'b1;
            if (bus.in_last) state_d = ST_DONE;
          end else begin
            wdata_d = enc_word;
            last_d  = bus.in_last;
            state_d = ST_WRITE;
`ifdef HALT_APPEND_EN
            halt_d  = 1'b0;
`endif
          end
        end
      end
      ST_WRITE: begin
        count_d = count_q + 1'b1;
        // The address saturates at the top word; FULL stops further writes.
        if (at_end) full_d = 1'b1;
        else        addr_d = addr_q + 1'b1;
        if (last_q)      state_d = ST_DONE;
        else if (at_end) state_d = ST_FULL;
        else             state_d = ST_READY;
`ifdef HALT_APPEND_EN
        if (last_q && !halt_q && !at_end) begin
          wdata_d = HALT_WORD;
          halt_d  = 1'b1;
          state_d = ST_WRITE;
        end
`endif
      end
      default: ;  // DONE and FULL hold until clear or rst
    endcase

    // Restart applies after any write in flight has had its cycle.
    if (clear) begin
      state_d = ST_READY;
      addr_d  = '0;
      count_d = '0;
      err_d   = 1'b0;
      full_d  = 1'b0;
      last_d  = 1'b0;
`ifdef HALT_APPEND_EN
      halt_d  = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_READY;
      addr_q  <= '0;
      count_q <= '0;
      wdata_q <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
      full_q  <= 1'b0;
`ifdef HALT_APPEND_EN
      halt_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      wdata_q <= wdata_d;
      last_q  <= last_d;
      err_q   <= err_d;
      full_q  <= full_d;
`ifdef HALT_APPEND_EN
      halt_q  <= halt_d;
`endif
    end
  end

  assign bus.imem_we    = (state_q == ST_WRITE);
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign word_count     = count_q;
  assign full           = full_q;
  assign done           = (state_q == ST_DONE);
  assign err            = err_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Scoreboard bench for instr_encoder_loader with an 8-word memory: the driver pushes expected
// writes from a word-list model at each accepted bundle; a negedge monitor pops and compares.
module tb_instr_encoder_loader;
  localparam int unsigned AW    = 3;
  localparam int unsigned DEPTH = 1 << AW;

  logic          clk;
  logic          rst;
  logic          clear;
  logic [AW:0]   word_count;
  logic          full;
  logic          done;
  logic          err;

  instr_encoder_loader_if #(.ADDR_W(AW)) bus ();

  instr_encoder_loader #(.ADDR_W(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .bus        (bus.slave),
    .word_count (word_count),
    .full       (full),
    .done       (done),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;

  // Reference model: the program image is just a count of words laid down from address 0.
  int   m_count = 0;
  bit   m_err   = 1'b0;
  bit   m_done  = 1'b0;
  bit   m_full  = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  task automatic fail_now(input string name);
    checks++;
    $display("FAIL %s: got event, required none", name);
  endtask

  function automatic bit ref_legal(input logic [1:0] kind, input logic [12:0] imm);
    int v;
    v = int'($signed(imm));
    if (kind == 2'd0 || kind == 2'd1) return (v >= -2048) && (v <= 2047);
    if (kind == 2'd3) return (v % 2) == 0;
    return 1'b1;
  endfunction

  function automatic logic [31:0] ref_enc(input logic [1:0] kind, input logic [3:0] sel,
                                          input logic [4:0] rd, input logic [4:0] rs1,
                                          input logic [4:0] rs2, input logic [12:0] imm);
    int unsigned i, w;
    i = 32'(imm);
    w = (32'(rs1) << 15);
    case (kind)
      2'd0: w = w | ((i & 32'hfff) << 20) | (32'd2 << 12) | (32'(rd) << 7) | 32'h03;
      2'd1: w = w | (((i >> 5) & 32'h7f) << 25) | (32'(rs2) << 20) | (32'd2 << 12)
                | ((i & 32'h1f) << 7) | 32'h23;
      2'd2: w = w | (sel[3] ? 32'h4000_0000 : 32'h0) | (32'(rs2) << 20)
                | ((32'(sel) & 32'h7) << 12) | (32'(rd) << 7) | 32'h33;
      default: w = w | (((i >> 12) & 32'h1) << 31) | (((i >> 5) & 32'h3f) << 25)
                   | (32'(rs2) << 20) | (((i >> 1) & 32'hf) << 8) | (((i >> 11) & 32'h1) << 7)
                   | 32'h63;
    endcase
    return w;
  endfunction

  task automatic model_restart();
    m_count = 0;
    m_err   = 1'b0;
    m_done  = 1'b0;
    m_full  = 1'b0;
  endtask

  task automatic model_push(input logic [31:0] w);
    exp_t e;
    e.addr = AW'(m_count);
    e.data = w;
    exp_q.push_back(e);
    m_count++;
    if (m_count == DEPTH) m_full = 1'b1;
  endtask

  task automatic model_accept(input logic [1:0] kind, input logic [3:0] sel, input logic [4:0] rd,
                              input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [12:0] imm, input logic last);
    if (!ref_legal(kind, imm)) begin
      m_err = 1'b1;
      if (last) m_done = 1'b1;
      return;
    end
    model_push(ref_enc(kind, sel, rd, rs1, rs2, imm));
    if (last) begin
      m_done = 1'b1;
`ifdef HALT_APPEND_EN
      if (!m_full) model_push(32'h0000_0063);
`endif
    end
  endtask

  // Monitor: every write strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (bus.imem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        fail_now("unexpected_write");
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 64'(bus.imem_addr), 64'(e.addr));
        check("wr_data", 64'(bus.imem_wdata), 64'(e.data));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input logic [1:0] kind, input logic [3:0] sel, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [12:0] imm,
                       input logic last);
    bus.in_kind    = kind;
    bus.in_alu_sel = sel;
    bus.in_rd      = rd;
    bus.in_rs1     = rs1;
    bus.in_rs2     = rs2;
    bus.in_imm     = imm;
    bus.in_last    = last;
    bus.in_valid   = 1'b1;
  endtask

  // Called just after a negedge; returns at the negedge that follows the accepting edge.
  task automatic send(input logic [1:0] kind, input logic [3:0] sel, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [12:0] imm,
                      input logic last, input bit chk, input logic [31:0] cst);
    bit   accepted;
    logic rdy;
    accepted = 1'b0;
    drive(kind, sel, rd, rs1, rs2, imm, last);
    for (int c = 0; c < 20 && !accepted; c++) begin
      #1;
      rdy = bus.in_ready;
      @(posedge clk);
      if (rdy === 1'b1) begin
        accepted = 1'b1;
        model_accept(kind, sel, rd, rs1, rs2, imm, last);
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    if (!accepted) begin
      fail_now("accept_timeout");
    end else begin
      check("we_after_accept", 64'(bus.imem_we), 64'(ref_legal(kind, imm)));
      if (chk) check("encoded_word", 64'(bus.imem_wdata), 64'(cst));
    end
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk);
    model_restart();
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    model_restart();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_status(input string tag);
    check({tag, "_count"}, 64'(word_count), 64'(m_count));
    check({tag, "_full"}, 64'(full), 64'(m_full));
    check({tag, "_done"}, 64'(done), 64'(m_done));
    check({tag, "_err"}, 64'(err), 64'(m_err));
    check({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_we"}, 64'(bus.imem_we), 64'd0);
    check({tag, "_addr"}, 64'(bus.imem_addr), 64'd0);
    check({tag, "_wdata"}, 64'(bus.imem_wdata), 64'd0);
    check({tag, "_ready"}, 64'(bus.in_ready), 64'd1);
    check_status(tag);
  endtask

  task automatic send_random(input logic last);
    logic [1:0]  kind;
    logic [12:0] imm;
    kind = 2'($urandom_range(0, 3));
    imm  = 13'($urandom);
    if ($urandom_range(0, 3) != 0) begin
      if (kind == 2'd3) imm[0] = 1'b0;
      else              imm[12] = imm[11];
    end
    send(kind, 4'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), imm, last, 1'b0, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    clear = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_kind = '0;
    bus.in_alu_sel = '0;
    bus.in_rd = '0;
    bus.in_rs1 = '0;
    bus.in_rs2 = '0;
    bus.in_imm = '0;
    bus.in_last = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // Single lw, then readiness returns right after the write cycle.
    send(2'd0, 4'd0, 5'd5, 5'd2, 5'd0, 13'd8, 1'b0, 1'b1, 32'h0081_2283);
    idle(1);
    check("lw_count", 64'(word_count), 64'd1);
    check("ready_after_write", 64'(bus.in_ready), 64'd1);

    // Program stream ending in a last-flagged branch.
    do_reset();
    send(2'd1, 4'd0,    5'd0, 5'd2, 5'd5, 13'd12, 1'b0, 1'b1, 32'h0051_2623);
    send(2'd2, 4'b0000, 5'd3, 5'd1, 5'd2, 13'd0,  1'b0, 1'b1, 32'h0020_81B3);
    send(2'd2, 4'b1000, 5'd3, 5'd1, 5'd2, 13'd0,  1'b0, 1'b1, 32'h4020_81B3);
    send(2'd3, 4'd0,    5'd0, 5'd1, 5'd2, -13'sd8, 1'b1, 1'b1, 32'hFE20_8CE3);
    idle(4);
    check_status("stream");
    check("done_not_ready", 64'(bus.in_ready), 64'd0);

    // Illegal bundles: rejected, sticky err, address unchanged.
    do_clear();
    send(2'd0, 4'd0, 5'd1, 5'd1, 5'd0, 13'd2048, 1'b0, 1'b0, '0);
    send(2'd3, 4'd0, 5'd0, 5'd1, 5'd2, 13'd3, 1'b0, 1'b0, '0);
    idle(2);
    check_status("illegal");
    send(2'd2, 4'd0, 5'd4, 5'd1, 5'd2, 13'd0, 1'b0, 1'b1, 32'h0020_8233);
    idle(2);
    check_status("after_illegal");

    // Fill all eight words, then a further bundle must not be taken.
    do_clear();
    for (int k = 0; k < DEPTH; k++) begin
      send(2'd2, 4'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 13'd0, 1'b0, 1'b0, '0);
    end
    idle(2);
    check_status("full");
    drive(2'd0, 4'd0, 5'd1, 5'd1, 5'd0, 13'd4, 1'b0);
    for (int k = 0; k < 3; k++) begin
      #1;
      check("full_not_ready", 64'(bus.in_ready), 64'd0);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    do_clear();
    check_status("full_cleared");
    send(2'd0, 4'd0, 5'd7, 5'd3, 5'd0, 13'h1FFC, 1'b0, 1'b1, 32'hFFC1_A383);

    // Reset in the write cycle with in_valid held high.
    send(2'd2, 4'd0, 5'd1, 5'd2, 5'd3, 13'd0, 1'b0, 1'b0, '0);
    bus.in_valid = 1'b1;
    do_reset();
    bus.in_valid = 1'b0;
    check_reset_outputs("rst_mid_write");

    // clear and in_valid together: refused that cycle, taken next at address 0.
    send(2'd2, 4'd0, 5'd1, 5'd2, 5'd3, 13'd0, 1'b0, 1'b0, '0);
    idle(1);
    drive(2'd1, 4'd0, 5'd0, 5'd6, 5'd9, 13'd20, 1'b0);
    clear = 1'b1;
    #1;
    check("clear_blocks_ready", 64'(bus.in_ready), 64'd0);
    @(posedge clk);
    model_restart();
    @(negedge clk);
    clear = 1'b0;
    send(2'd1, 4'd0, 5'd0, 5'd6, 5'd9, 13'd20, 1'b0, 1'b0, '0);
    idle(2);
    check_status("clear_valid");

    // Random programs, some long enough to fill the memory.
    for (int p = 0; p < 14; p++) begin
      int n;
      do_clear();
      n = int'($urandom_range(1, 11));
      for (int k = 0; k < n; k++) begin
        if (m_done || m_full) break;
        send_random(logic'(k == n - 1));
        idle(int'($urandom_range(0, 2)));
      end
      idle(4);
      check_status("random");
    end

    idle(2);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
